sram_sdi_ctrl: RTL and testbench

//  Controller for the 23LC1024-style serial SRAM on the devboard. After reset it forces the device

---
 rtl/sram_sdi_ctrl_pkg.sv | 33 +++
 rtl/sram_sdi_ctrl_shifter.sv | 54 +++++
 rtl/sram_sdi_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sram_sdi_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_sdi_ctrl_pkg.sv
// Shared opcodes, FSM encodings and request bundle
// for the serial SRAM SDI controller.
package sram_sdi_ctrl_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_EDIO  = 8'h3B;
  localparam logic [7:0] OP_RSTIO = 8'hFF;

  localparam logic [3:0] S_INIT_RSTIO = 4'd0;
  localparam logic [3:0] S_GAP        = 4'd1;
  localparam logic [3:0] S_INIT_EDIO  = 4'd2;
  localparam logic [3:0] S_IDLE       = 4'd3;
  localparam logic [3:0] S_CMD        = 4'd4;
  localparam logic [3:0] S_ADDR       = 4'd5;
  localparam logic [3:0] S_DUMMY      = 4'd6;
  localparam logic [3:0] S_RDATA      = 4'd7;
  localparam logic [3:0] S_WDATA      = 4'd8;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic        port_b;
  } sdi_req_t;

  function automatic logic [23:0] msb_byte(
    input logic [7:0] b
  );
    return {b, 16'h0000};
  endfunction

endpackage

// File: rtl/sram_sdi_ctrl_shifter.sv
// Shift register, sck phase generator and pair counter
// for the serial SRAM link.
module sram_sdi_ctrl_shifter
  import sram_sdi_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        pre,
  input  logic [23:0] load_val,
  input  logic [3:0]  load_cnt,
  input  logic        one_bit,
  input  logic [1:0]  din,
  output logic [1:0]  top2,
  output logic [5:0]  low6,
  output logic        sck,
  output logic        last
);

  logic [23:0] sr;
  logic [3:0]  cnt;
  logic        ph;
  logic        wait_q;

  // wait_q holds sck low one clk after cs falls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr     <= '0;
      cnt    <= '0;
      ph     <= 1'b0;
      wait_q <= 1'b0;
    end else if (load) begin
      sr     <= load_val;
      cnt    <= load_cnt;
      ph     <= 1'b0;
      wait_q <= pre;
    end else if (wait_q) begin
      wait_q <= 1'b0;
    end else if (cnt != 4'd0) begin
      ph <= ~ph;
      if (ph) begin
        cnt <= cnt - 4'd1;
        sr  <= one_bit ? {sr[22:0], 1'b0}
                       : {sr[21:0], din};
      end
    end
  end

  assign top2 = sr[23:22];
  assign low6 = sr[5:0];
  assign sck  = ph;
  assign last = ph && (cnt == 4'd1);

endmodule

// File: rtl/sram_sdi_ctrl.sv
// Serial SRAM controller: SDI init, round-robin
// arbitration of two byte requesters, frame FSM.
module sram_sdi_ctrl
  import sram_sdi_ctrl_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int CS_GAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic              b_ack,
  output logic [7:0]        rdata,
  output logic              ready,
  output logic              sck,
  output logic              cs,
  inout  wire  [1:0]        d
);

  logic [3:0]  state;
  logic [3:0]  nxt;
  logic [7:0]  gap_cnt;
  logic        gap_done;
  sdi_req_t    cur;
  logic        prio_b;
  logic        gnt_a;
  logic        gnt_b;
  logic        ld;
  logic        ld_pre;
  logic [23:0] ld_val;
  logic [3:0]  ld_cnt;
  logic        one_bit;
  logic        last;
  logic [1:0]  top2;
  logic [5:0]  low6;
  logic [1:0]  oe;
  logic [1:0]  dout;
  logic        g_we;

  assign gap_done = gap_cnt == 8'(CS_GAP - 1);
  assign gnt_a = ready && state == S_IDLE && a_req
              && (!b_req || !prio_b);
  assign gnt_b = ready && state == S_IDLE && b_req
              && !gnt_a;
  assign g_we = gnt_a ? a_we : b_we;
  assign one_bit = state == S_INIT_EDIO;
  assign cs = state == S_GAP || state == S_IDLE;

  always_comb begin
    ld     = 1'b0;
    ld_pre = 1'b0;
    ld_val = '0;
    ld_cnt = 4'd4;
    unique case (1'b1)
      state == S_GAP && gap_done
        && nxt == S_INIT_RSTIO: begin
        ld = 1'b1; ld_pre = 1'b1;
        ld_val = {OP_RSTIO, OP_RSTIO, OP_RSTIO};
        ld_cnt = 4'd8;
      end
      state == S_GAP && gap_done
        && nxt == S_INIT_EDIO: begin
        ld = 1'b1; ld_pre = 1'b1;
        ld_val = msb_byte(OP_EDIO);
        ld_cnt = 4'd8;
      end
      gnt_a || gnt_b: begin
        ld = 1'b1; ld_pre = 1'b1;
        ld_val = msb_byte(g_we ? OP_WRITE : OP_READ);
      end
      state == S_CMD && last: begin
        ld = 1'b1;
        ld_val = cur.addr;
        ld_cnt = 4'd12;
      end
      state == S_ADDR && last: begin
        ld = 1'b1;
        ld_val = cur.we ? msb_byte(cur.wdata) : '0;
      end
      state == S_DUMMY && last: ld = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_GAP;
      nxt     <= S_INIT_RSTIO;
      gap_cnt <= '0;
      cur     <= '0;
      prio_b  <= 1'b0;
      ready   <= 1'b0;
      rdata   <= '0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      unique case (state)
        S_GAP: begin
          if (gap_done) begin
            state   <= nxt;
            gap_cnt <= '0;
            if (nxt == S_IDLE) ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        S_IDLE: begin
          if (gnt_a || gnt_b) begin
            state  <= S_CMD;
            prio_b <= gnt_a;
            cur <= gnt_a
              ? '{we: a_we, addr: 24'(a_addr),
                  wdata: a_wdata, port_b: 1'b0}
              : '{we: b_we, addr: 24'(b_addr),
                  wdata: b_wdata, port_b: 1'b1};
          end
        end
        S_INIT_RSTIO: if (last) begin
          state <= S_GAP;
          nxt   <= S_INIT_EDIO;
        end
        S_INIT_EDIO: if (last) begin
          state <= S_GAP;
          nxt   <= S_IDLE;
        end
        S_CMD:   if (last) state <= S_ADDR;
        S_ADDR:  if (last)
          state <= cur.we ? S_WDATA : S_DUMMY;
        S_DUMMY: if (last) state <= S_RDATA;
        S_RDATA, S_WDATA: if (last) begin
          state <= S_GAP;
          nxt   <= S_IDLE;
          a_ack <= ~cur.port_b;
          b_ack <= cur.port_b;
          if (state == S_RDATA) rdata <= {low6, d};
        end
        default: state <= S_GAP;
      endcase
    end
  end

  always_comb begin
    oe = 2'b00;
    unique case (state)
      S_INIT_EDIO: oe = 2'b01;
      S_INIT_RSTIO, S_CMD, S_ADDR, S_WDATA:
        oe = 2'b11;
      default: oe = 2'b00;
    endcase
  end

  assign dout = one_bit ? {1'b0, top2[1]} : top2;
  assign d[0] = oe[0] ? dout[0] : 1'bz;
  assign d[1] = oe[1] ? dout[1] : 1'bz;

  sram_sdi_ctrl_shifter u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .pre      (ld_pre),
    .load_val (ld_val),
    .load_cnt (ld_cnt),
    .one_bit  (one_bit),
    .din      (d),
    .top2     (top2),
    .low6     (low6),
    .sck      (sck),
    .last     (last)
  );

endmodule

// File: tb/tb_sram_sdi_ctrl.sv
// Directed bench for sram_sdi_ctrl with a behavioural
// SPI/SDI serial SRAM model on the d bus.
module tb_sram_sdi_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [18:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic        a_ack;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [18:0] b_addr = '0;
  logic [7:0]  b_wdata = '0;
  logic        b_ack;
  logic [7:0]  rdata;
  logic        ready, sck, cs;
  wire  [1:0]  d;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pullup (d[0]);
  pullup (d[1]);

  sram_sdi_ctrl #(.ADDR_W(19), .CS_GAP(2)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_ack(b_ack),
    .rdata(rdata), .ready(ready), .sck(sck),
    .cs(cs), .d(d)
  );

  // SRAM model: starts in SPI mode, samples on sck rise,
  // drives read data after sck fall
  logic        m_sdi = 1'b0, m_fm = 1'b0, m_oe = 1'b0;
  logic [1:0]  m_out = 2'b00;
  logic [31:0] m_sh = '0;
  logic        m_all11 = 1'b1, m_d1hi = 1'b1;
  logic [7:0]  m_cmd = '0, m_wd = '0, m_rs = '0;
  logic [23:0] m_addr = '0;
  int          m_n = 0, m_last_n = 0;
  int          m_rstio = 0, m_edio = 0;
  bit   [7:0]  mem [bit [23:0]];

  assign d = m_oe ? m_out : 2'bzz;

  always @(negedge cs) begin
    m_n = 0; m_sh = '0; m_fm = m_sdi;
    m_all11 = 1'b1; m_d1hi = 1'b1;
  end

  always @(posedge cs) begin
    m_oe = 1'b0;
    m_last_n = m_n;
  end

  always @(posedge sck) if (!cs) begin
    m_n++;
    m_all11 &= (d == 2'b11);
    m_d1hi &= d[1];
    if (!m_fm) begin
      m_sh = {m_sh[30:0], d[0]};
      if (m_n == 8) begin
        if (m_sh[7:0] == 8'h3B && m_d1hi) begin
          m_sdi = 1'b1; m_edio++;
        end else if (m_sh[7:0] == 8'hFF && m_all11)
          m_rstio++;
      end
    end else begin
      m_sh = {m_sh[29:0], d};
      if (m_n == 4) begin
        m_cmd = m_sh[7:0];
        if (m_cmd == 8'hFF && m_all11) begin
          m_sdi = 1'b0; m_rstio++;
        end
      end
      if (m_n == 16) m_addr = m_sh[23:0];
      if (m_n == 20 && m_cmd == 8'h02) begin
        m_wd = m_sh[7:0];
        mem[m_addr] = m_wd;
      end
      if (m_n == 20 && m_cmd == 8'h03)
        m_rs = mem.exists(m_addr) ? mem[m_addr] : 8'h00;
    end
  end

  always @(negedge sck) begin
    if (!cs && m_fm && m_cmd == 8'h03
        && m_n >= 20 && m_n < 24) begin
      m_oe = 1'b1;
      m_out = m_rs[7:6];
      m_rs = {m_rs[5:0], 2'b00};
    end else begin
      m_oe = 1'b0;
    end
  end

  // frame/gap/ack monitors
  int   low_run = 0, low_last = 0;
  int   hi_run = 0, min_gap = 1000;
  int   both_ack = 0, ack_bad = 0;
  logic cs_prev = 1'b1;

  always @(negedge clk) begin
    if (!cs) low_run++;
    else if (low_run != 0) begin
      low_last = low_run; low_run = 0;
    end
    if (cs) hi_run++;
    else begin
      if (hi_run != 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
    end
    if (a_ack && b_ack) both_ack++;
    if ((a_ack || b_ack) && !(cs && !cs_prev)) ack_bad++;
    cs_prev = cs;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit pb, input bit we,
                      input logic [18:0] addr,
                      input logic [7:0] wd);
    int t;
    @(negedge clk);
    if (pb) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    t = 0;
    while (!(pb ? b_ack : a_ack) && t < 300) begin
      @(negedge clk); t++;
    end
    check("ack_timeout", 32'(t < 300), 1);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t, nacks, first;
    bit seen;

    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_d", d, 2'b11);
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_ready", ready, 0);
    check("rst_rdata", rdata, 0);

    reset = 1'b1;
    t = 0;
    while (!ready && t < 300) begin @(negedge clk); t++; end
    check("ready_timeout", 32'(t < 300), 1);
    check("init_rstio", m_rstio, 1);
    check("init_edio", m_edio, 1);
    check("init_sdi", m_sdi, 1);
    check("init_edio_sck", m_last_n, 8);

    xfer(0, 1, 19'h12345, 8'hA5);
    check("wr_sck", m_last_n, 20);
    check("wr_cs_low", low_last, 41);
    check("wr_addr", m_addr, 24'h012345);
    check("wr_data", m_wd, 8'hA5);
    xfer(0, 0, 19'h12345, 8'h00);
    check("rd_sck", m_last_n, 24);
    check("rd_cs_low", low_last, 49);
    check("rd_data", rdata, 8'hA5);

    xfer(1, 1, 19'h00000, 8'h3C);
    check("b_wr_addr", m_addr, 24'h000000);
    check("wr_keeps_rdata", rdata, 8'hA5);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1;
      a_addr = 19'(32'h100 + i); a_wdata = 8'(8'h10 + i);
      b_req = 1'b1; b_we = 1'b1;
      b_addr = 19'(32'h200 + i); b_wdata = 8'(8'h20 + i);
      nacks = 0; first = -1; t = 0;
      while (nacks < 2 && t < 300) begin
        @(negedge clk); t++;
        if (a_ack) begin
          if (first < 0) first = 0;
          a_req = 1'b0; nacks++;
        end
        if (b_ack) begin
          if (first < 0) first = 1;
          b_req = 1'b0; nacks++;
        end
      end
      a_req = 1'b0; b_req = 1'b0;
      check("rr_nacks", nacks, 2);
      check("rr_first_a", first, 0);
      check("rr_mem_a", mem[24'(32'h100 + i)], 8'(8'h10 + i));
      check("rr_mem_b", mem[24'(32'h200 + i)], 8'(8'h20 + i));
    end
    check("both_ack", both_ack, 0);

    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1;
    a_addr = 19'h0ABCD; a_wdata = 8'h77;
    repeat (10) @(negedge clk);
    a_addr = 19'h11111; a_wdata = 8'h88;
    t = 0;
    while (!a_ack && t < 300) begin @(negedge clk); t++; end
    check("latch_timeout", 32'(t < 300), 1);
    a_req = 1'b0;
    @(negedge clk);
    check("latch_addr", m_addr, 24'h00ABCD);
    check("latch_data", m_wd, 8'h77);
    check("latch_no_alias", mem.exists(24'h011111), 0);

    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 19'h12345;
    repeat (16) @(negedge clk);
    check("abort_in_addr", 32'(m_n > 4 && m_n < 16), 1);
    reset = 1'b0;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sck", sck, 0);
    check("abort_d", d, 2'b11);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= a_ack | b_ack;
    end
    check("abort_no_ack", seen, 0);
    check("abort_ready", ready, 0);
    reset = 1'b1;
    t = 0;
    while (!a_ack && t < 500) begin @(negedge clk); t++; end
    check("reinit_timeout", 32'(t < 500), 1);
    a_req = 1'b0;
    @(negedge clk);
    check("reinit_rstio", m_rstio, 2);
    check("reinit_edio", m_edio, 2);
    check("reinit_rdata", rdata, 8'hA5);
    check("reinit_cs_low", low_last, 49);

    xfer(0, 1, 19'h7FFFF, 8'h5A);
    check("top_addr", m_addr, 24'h07FFFF);
    check("top_mem", mem[24'h07FFFF], 8'h5A);
    xfer(1, 0, 19'h00000, 8'h00);
    check("zero_addr", m_addr, 24'h000000);
    check("zero_rdata", rdata, 8'h3C);
    check("min_gap", 32'(min_gap >= 2), 1);
    check("both_ack_end", both_ack, 0);
    check("ack_in_gap", ack_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
